// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command port into APB transfers
// (IDLE -> SETUP -> ACCESS) and returns a one-cycle response pulse.
// Optional feature macro: APB_MASTER_TIMEOUT_EN adds an ACCESS wait-state
// limit of TIMEOUT_CYCLES; the transfer is aborted with rsp_err=1 when it is hit.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // The wait-state counter is 16 bits wide, which bounds the legal limit.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
        $error("apb_master_bridge: TIMEOUT_CYCLES must be in 2..65535");
    end

    state_t            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              cmd_accept;
    logic              xfer_done;
    logic              xfer_abort;

    assign cmd_accept = (state_q == ST_IDLE) && cmd_valid;
    assign xfer_done  = (state_q == ST_ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // Abort on the edge that ends the TIMEOUT_CYCLES-th wait cycle; a pready
    // arriving in that same cycle still completes normally.
    assign xfer_abort = (state_q == ST_ACCESS) && !pready && (tmo_cnt_q == TMO_LAST);

    // Wait-state counter: cleared while in SETUP (entry to ACCESS), counts stalled ACCESS cycles.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_SETUP) begin
            tmo_cnt_d = 16'd0;
        end else if ((state_q == ST_ACCESS) && !pready) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    // Wait-state counter register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign xfer_abort = 1'b0;
`endif

    // State and output registers; everything returns to its idle value on reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic: SETUP lasts one cycle, ACCESS ends on pready or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (xfer_done || xfer_abort) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output logic: APB strobes follow the next state so they are registered;
    // the command is captured at accept and held until the next accept.
    always_comb begin
        psel_d      = (state_d != ST_IDLE);
        penable_d   = (state_d == ST_ACCESS);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = xfer_done || xfer_abort;
        rsp_err_d   = xfer_abort;
        rsp_rdata_d = rsp_rdata_q;
        if (cmd_accept) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
        end
        if (xfer_done) begin
            rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (xfer_abort) begin
            rsp_rdata_d = '0;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed testbench for apb_master_bridge (TIMEOUT_CYCLES=4).
module tb_apb_master_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              pclk = 1'b0;
    logic              preset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    int n_checks = 0;
    int n_errors = 0;
    int rsp_seen = 0;

    apb_master_bridge #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .pready(pready),
        .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0010;
        cmd_wdata = 32'h0000_0055;
        pready    = 1'b1;
        prdata    = 32'h0;

        // Reset held 2 cycles with a command offered
        tick();
        tick();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_busy", busy, 0);
        preset    = 1'b0;
        cmd_valid = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        tick();
        chk("idle_psel", psel, 0);

        // Write, pready already high (ignored in SETUP), completes on first ACCESS
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0008;
        cmd_wdata = 32'hA5A5_1234;
        pready    = 1'b1;
        prdata    = 32'h1111_2222;
        chk("wr_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("wr_setup_psel", psel, 1);
        chk("wr_setup_penable", penable, 0);
        chk("wr_setup_paddr", paddr, 32'h8);
        chk("wr_setup_pwdata", pwdata, 32'hA5A5_1234);
        chk("wr_setup_pwrite", pwrite, 1);
        chk("wr_setup_busy", busy, 1);
        chk("wr_setup_ready", cmd_ready, 0);
        tick();
        chk("wr_acc_psel", psel, 1);
        chk("wr_acc_penable", penable, 1);
        chk("wr_acc_paddr", paddr, 32'h8);
        chk("wr_acc_pwdata", pwdata, 32'hA5A5_1234);
        chk("wr_acc_pwrite", pwrite, 1);
        chk("wr_acc_rsp_valid", rsp_valid, 0);
        tick();
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_psel", psel, 0);
        chk("wr_rsp_penable", penable, 0);
        chk("wr_rsp_ready", cmd_ready, 1);
        chk("wr_rsp_paddr_hold", paddr, 32'h8);
        tick();
        chk("wr_rsp_pulse_end", rsp_valid, 0);

        // Read with one wait state
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0004;
        pready    = 1'b0;
        prdata    = 32'hDEAD_BEEF;
        tick();
        cmd_valid = 1'b0;
        chk("rd_setup_psel", psel, 1);
        chk("rd_setup_penable", penable, 0);
        chk("rd_setup_pwrite", pwrite, 0);
        chk("rd_setup_ready", cmd_ready, 0);
        tick();
        chk("rd_acc1_penable", penable, 1);
        chk("rd_acc1_ready", cmd_ready, 0);
        chk("rd_acc1_rsp_valid", rsp_valid, 0);
        tick();
        chk("rd_acc2_penable", penable, 1);
        chk("rd_acc2_paddr", paddr, 32'h4);
        chk("rd_acc2_ready", cmd_ready, 0);
        chk("rd_acc2_rsp_valid", rsp_valid, 0);
        pready = 1'b1;
        prdata = 32'h0000_00FF;
        tick();
        pready = 1'b0;
        prdata = 32'h0;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 32'hFF);
        chk("rd_rsp_err", rsp_err, 0);
        tick();
        chk("rd_rsp_pulse_end", rsp_valid, 0);
        chk("rd_rdata_hold", rsp_rdata, 32'hFF);

        // Back-to-back: cmd_valid held, command changed after first accept
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0100;
        cmd_wdata = 32'h0000_0001;
        pready    = 1'b1;
        tick();
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0200;
        cmd_wdata = 32'h0000_0002;
        prdata    = 32'h0000_0077;
        chk("b2b_1_setup_paddr", paddr, 32'h100);
        tick();
        chk("b2b_1_acc_paddr", paddr, 32'h100);
        chk("b2b_1_acc_pwrite", pwrite, 1);
        tick();
        chk("b2b_1_rsp_valid", rsp_valid, 1);
        chk("b2b_gap_psel", psel, 0);
        chk("b2b_gap_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_2_setup_psel", psel, 1);
        chk("b2b_2_setup_penable", penable, 0);
        chk("b2b_2_setup_paddr", paddr, 32'h200);
        chk("b2b_2_setup_pwrite", pwrite, 0);
        chk("b2b_2_setup_rsp_valid", rsp_valid, 0);
        tick();
        tick();
        chk("b2b_2_rsp_valid", rsp_valid, 1);
        chk("b2b_2_rsp_rdata", rsp_rdata, 32'h77);

        // Stalled slave: pready held low
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_000C;
        pready    = 1'b0;
        prdata    = 32'h0000_ABCD;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("stall_acc1_penable", penable, 1);
`ifdef APB_MASTER_TIMEOUT_EN
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("tmo_acc%0d_penable", i), penable, 1);
            chk($sformatf("tmo_acc%0d_rsp_valid", i), rsp_valid, 0);
        end
        tick();
        chk("tmo_psel", psel, 0);
        chk("tmo_penable", penable, 0);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_rdata", rsp_rdata, 0);
        chk("tmo_busy", busy, 0);
        tick();
        chk("tmo_pulse_end", rsp_valid, 0);

        // pready arriving in the limit cycle wins
        cmd_valid = 1'b1;
        prdata    = 32'h0000_0042;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("race_acc4_penable", penable, 1);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        chk("race_rsp_valid", rsp_valid, 1);
        chk("race_rsp_err", rsp_err, 0);
        chk("race_rsp_rdata", rsp_rdata, 32'h42);

        // Get into a wait state for the mid-transfer reset
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rsp_valid) rsp_seen++;
        end
        chk("notmo_penable", penable, 1);
        chk("notmo_busy", busy, 1);
        chk("notmo_rsp_seen", rsp_seen, 0);
        chk("notmo_rsp_err", rsp_err, 0);
`endif

        // Reset during an ACCESS wait state
        chk("midrst_pre_penable", penable, 1);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_paddr", paddr, 0);
        tick();
        chk("midrst_no_rsp", rsp_valid, 0);

        // New command after reset completes normally
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0020;
        pready    = 1'b1;
        prdata    = 32'h0BAD_F00D;
        tick();
        cmd_valid = 1'b0;
        chk("post_setup_paddr", paddr, 32'h20);
        tick();
        chk("post_acc_penable", penable, 1);
        tick();
        chk("post_rsp_valid", rsp_valid, 1);
        chk("post_rsp_err", rsp_err, 0);
        chk("post_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
